// File: rtl/launchpad_mode_led.sv
// rtl/launchpad_mode_led.sv - mode latch, record FSM and blinking LED banks; MODE_DEBOUNCE_EN adds key debounce
module launchpad_mode_led #(
    parameter int NUM_MODES  = 4,
    parameter int REC_MODE   = 2,
    parameter int LOOP_MODE  = 3,
    parameter int BLINK_HALF = 12000000,
    parameter int HOLD_CYC   = 72000000,
    parameter int WAIT_CYC   = 72000000,
    parameter int DEB_CYC    = 240000,
    localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
    localparam int LW = 2 * NUM_MODES
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [NUM_MODES-1:0] MODE_KEY,
    input  logic          Mode_Switch,
    output logic [LW-1:0] LED,
    output logic [MW-1:0] MODE,
    output logic          MODE_VALID,
    output logic          REC_ARMED,
    output logic          REC_ACTIVE,
    output logic          BLINK
);

    localparam int BW = $clog2(BLINK_HALF);
    localparam int HW = $clog2(HOLD_CYC);
    localparam int WW = $clog2(WAIT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_REC} rec_state_t;

    logic [NUM_MODES-1:0] key;

`ifdef MODE_DEBOUNCE_EN
    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    logic [DW-1:0] deb_cnt [NUM_MODES];

    // Filtered bit follows the raw bit only after DEB_CYC consecutive differing samples
    always_ff @(posedge CLK) begin
        if (RESET) begin
            key <= '0;
            for (int i = 0; i < NUM_MODES; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_MODES; i++) begin
                if (MODE_KEY[i] != key[i]) begin
                    if (deb_cnt[i] == DW'(DEB_CYC - 1)) begin
                        key[i]     <= MODE_KEY[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign key = MODE_KEY;
`endif

    logic          key_any;
    logic [MW-1:0] key_sel;

    always_comb begin
        key_any = |key;
        key_sel = '0;
        for (int i = NUM_MODES - 1; i >= 0; i--) begin
            if (key[i]) key_sel = MW'(i);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            MODE       <= '0;
            MODE_VALID <= 1'b0;
        end else if (key_any) begin
            MODE       <= key_sel;
            MODE_VALID <= 1'b1;
        end
    end

    logic [BW-1:0] blink_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            blink_cnt <= '0;
            BLINK     <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            BLINK     <= ~BLINK;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    rec_state_t    state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic          rec_key;
    logic          rec_run;

    assign rec_key = key[REC_MODE];
    assign rec_run = MODE_VALID && (MODE == MW'(REC_MODE));

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        wait_nxt  = wait_cnt;
        // Leaving the record mode aborts on the same edge the new mode latches
        if (key_any && key_sel != MW'(REC_MODE)) begin
            state_nxt = S_IDLE;
            hold_nxt  = '0;
            wait_nxt  = '0;
        end else if (rec_run) begin
            case (state)
                S_IDLE, S_REC: begin
                    if (!rec_key) begin
                        hold_nxt = '0;
                    end else if (hold_cnt == HW'(HOLD_CYC - 1)) begin
                        hold_nxt  = '0;
                        state_nxt = (state == S_IDLE) ? S_ARMED : S_IDLE;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                S_ARMED: begin
                    if (rec_key) begin
                        wait_nxt = '0;
                    end else if (wait_cnt == WW'(WAIT_CYC - 1)) begin
                        wait_nxt  = '0;
                        state_nxt = S_REC;
                    end else begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    assign REC_ARMED  = (state == S_ARMED);
    assign REC_ACTIVE = (state == S_REC);

    logic [LW-1:0] one_hot, pattern, bank_a_nxt, bank_b_nxt, bank_a, bank_b;

    always_comb begin
        one_hot    = LW'(1) << MODE;
        pattern    = ~(one_hot | (one_hot << NUM_MODES));
        bank_a_nxt = '1;
        bank_b_nxt = '1;
        if (MODE_VALID) begin
            if (MODE == MW'(REC_MODE) && state == S_REC) begin
                if (BLINK) begin
                    bank_a_nxt = pattern;
                    bank_b_nxt = pattern;
                end
            end else if (MODE == MW'(LOOP_MODE)) begin
                bank_a_nxt = pattern;
                if (BLINK) bank_b_nxt = pattern;
            end else begin
                bank_a_nxt = pattern;
                bank_b_nxt = pattern;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bank_a <= '1;
            bank_b <= '1;
        end else begin
            bank_a <= bank_a_nxt;
            bank_b <= bank_b_nxt;
        end
    end

    assign LED = Mode_Switch ? bank_b : bank_a;

endmodule

// File: tb/tb_launchpad_mode_led.sv
// tb/tb_launchpad_mode_led.sv - directed self-checking bench for launchpad_mode_led
module tb_launchpad_mode_led;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key;
    logic       sw;
    logic [7:0] led;
    logic [1:0] mode;
    logic       valid, armed, active, blink;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    launchpad_mode_led #(
        .NUM_MODES (4),
        .REC_MODE  (2),
        .LOOP_MODE (3),
        .BLINK_HALF(4),
        .HOLD_CYC  (8),
        .WAIT_CYC  (6),
        .DEB_CYC   (5)
    ) dut (
        .CLK        (clk),
        .RESET      (rst),
        .MODE_KEY   (key),
        .Mode_Switch(sw),
        .LED        (led),
        .MODE       (mode),
        .MODE_VALID (valid),
        .REC_ARMED  (armed),
        .REC_ACTIVE (active),
        .BLINK      (blink)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Blink level after edge c counted from reset release, half period 4
    function automatic logic bexp(input int c);
        return ((c / 4) % 2) == 1;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_led"}, led, 8'hFF);
        check({tag, "_mode"}, mode, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_armed"}, armed, 0);
        check({tag, "_active"}, active, 0);
        check({tag, "_blink"}, blink, 0);
    endtask

    initial begin
        rst = 1'b1;
        key = 4'b0000;
        sw  = 1'b0;
        step();
        step();
        check_reset_state("reset");
        rst = 1'b0;
        cyc = 0;

`ifdef MODE_DEBOUNCE_EN
        key = 4'b0010;
        repeat (4) step();
        key = 4'b0000;
        repeat (3) step();
        check("deb_glitch_mode", mode, 0);
        check("deb_glitch_valid", valid, 0);
        key = 4'b0010;
        repeat (5) step();
        check("deb_press_early", valid, 0);
        key = 4'b0000;
        step();
        check("deb_press_mode", mode, 1);
        check("deb_press_valid", valid, 1);
`else
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_led", led, 8'hFF);
            check("idle_valid", valid, 0);
            check("idle_blink", blink, bexp(cyc));
        end

        key = 4'b0110;
        step();
        check("sel1_mode", mode, 1);
        check("sel1_valid", valid, 1);
        key = 4'b0000;
        step();
        check("m1_led_a", led, 8'b11011101);
        sw = 1'b1;
        #1;
        check("m1_led_b", led, 8'b11011101);

        key = 4'b1000;
        step();
        check("sel3_mode", mode, 3);
        key = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            step();
            check("loop_led_b", led, bexp(cyc - 1) ? 8'b01110111 : 8'hFF);
        end
        sw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("loop_led_a", led, 8'b01110111);
            step();
        end

        key = 4'b0100;
        step();
        check("sel2_mode", mode, 2);
        key = 4'b0000;
        step();
        key = 4'b0100;
        repeat (7) step();
        key = 4'b0000;
        step();
        check("short_hold_armed", armed, 0);

        key = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            step();
            check("arm", armed, (i == 7) ? 1 : 0);
        end
        key = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            step();
            check("start_active", active, (i == 5) ? 1 : 0);
            check("armed_led", led, 8'b10111011);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            sw = i[0];
            #1;
            check("rec_led", led, bexp(cyc - 1) ? 8'b10111011 : 8'hFF);
        end

        key = 4'b0100;
        repeat (3) step();
        key = 4'b0000;
        step();
        check("rec_short_press", active, 1);

        key = 4'b0001;
        step();
        check("abort_mode", mode, 0);
        check("abort_active", active, 0);
        check("abort_armed", armed, 0);
        key = 4'b0000;
        step();
        sw = 1'b0;
        #1;
        check("m0_led_a", led, 8'b11101110);
        sw = 1'b1;
        #1;
        check("m0_led_b", led, 8'b11101110);

        key = 4'b0100;
        step();
        key = 4'b0000;
        step();
        key = 4'b0100;
        repeat (8) step();
        check("rearm", armed, 1);
        key = 4'b0000;
        rst = 1'b1;
        step();
        check_reset_state("midreset");
        rst = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/launchpad_mode_led.md
# launchpad_mode_led

Parametrised mode-indicator LED controller for the Launchpad pad front end. It latches one of `NUM_MODES` left-side mode keys and drives two active-low LED banks, selected by the panel mode switch. It adds a hold-to-arm / release-to-start record state machine and a blinking loop-mode indication, with all timing in parameters. It sits between the key scanner and the LED output pins.

## Interface
- `NUM_MODES`, 4: number of mode keys; LED width is `2*NUM_MODES`.
- `REC_MODE`, 2: mode index that owns the record state machine.
- `LOOP_MODE`, 3: mode index whose bank B blinks; must differ from `REC_MODE`.
- `BLINK_HALF`, 12000000: clock cycles per blink half-period; ≥2.
- `HOLD_CYC`, 72000000: cycles a key must be held to arm or stop recording; ≥2.
- `WAIT_CYC`, 72000000: release cycles from armed to recording; ≥2.
- `DEB_CYC`, 240000: debounce stable-count; only used with `MODE_DEBOUNCE_EN`.

Ports:
- `CLK` in 1: single clock.
- `RESET` in 1: synchronous, active-high reset, sampled on rising `CLK`.
- `MODE_KEY` in `NUM_MODES`: mode keys, 1 = pressed.
- `Mode_Switch` in 1: bank select; 0 = bank A, 1 = bank B.
- `LED` out `2*NUM_MODES`: active-low LED drive.
- `MODE` out `$clog2(NUM_MODES)`: current mode index.
- `MODE_VALID` out 1: a mode has been selected since reset.
- `REC_ARMED` out 1: record FSM in ARMED.
- `REC_ACTIVE` out 1: record FSM in RECORDING.
- `BLINK` out 1: blink phase.

## Operation
- **Mode latch**
  - Any key high selects the lowest-index high key; `MODE` and `MODE_VALID` register it.
  - No key high: the latch holds its value.
  - Simultaneous keys: the lowest index wins.
- **Blink**
  - Free-running counter 0..`BLINK_HALF-1`.
  - `BLINK` toggles on the cycle the counter wraps.
- **Mode pattern**
  - Pattern for mode m is all ones except bits m and m+`NUM_MODES`, which are 0.
- **Record FSM** (states IDLE, ARMED, RECORDING)
  - Runs only while `MODE==REC_MODE`. Selecting any other mode forces IDLE and clears `hold_cnt` and `wait_cnt` on the same edge `MODE` changes.
  - IDLE: rec key high increments `hold_cnt`. When `hold_cnt==HOLD_CYC-1`, go to ARMED and clear `hold_cnt`. Rec key low clears `hold_cnt`.
  - ARMED: rec key high keeps `wait_cnt` at 0. Rec key low increments `wait_cnt`. When `wait_cnt==WAIT_CYC-1`, go to RECORDING and clear `wait_cnt`.
  - RECORDING: rec key held for `HOLD_CYC` cycles (same `hold_cnt` rule) returns to IDLE. A shorter press is ignored.
- **Bank drive** (registered)
  - `MODE_VALID==0`: both banks all ones.
  - `REC_MODE`, IDLE or ARMED: both banks show the pattern.
  - `REC_MODE`, RECORDING: both banks show the pattern when `BLINK=1`, else all ones.
  - `LOOP_MODE`: bank A shows the pattern; bank B shows the pattern when `BLINK=1`, else all ones.
  - Any other mode: both banks show the pattern.
- **Output select**: `LED = Mode_Switch ? bankB : bankA`. This mux is combinational, so `Mode_Switch` takes effect in the same cycle.
- **Counter widths**: `$clog2` of the respective maximum. No counter saturates past its terminal value.

## Timing
- **Reset values**
  - `LED` = all ones; `MODE`=0; `MODE_VALID`=0; `REC_ARMED`=0; `REC_ACTIVE`=0; `BLINK`=0.
  - All counters 0; FSM = IDLE.
- **Latency**
  - Key sampled at edge n → `MODE` valid after edge n.
  - Banks reflect the new mode after edge n+1.
- **Arming**: rec key rising at edge k with mode already `REC_MODE` → `REC_ARMED` high after edge k+`HOLD_CYC`-1.
- **Start**: release at edge r → `REC_ACTIVE` high after edge r+`WAIT_CYC`-1.
- **Blink**: `BLINK` first rises after edge `BLINK_HALF`, measured from reset release.
- **Reset mid-operation**: everything returns to reset values on that edge. There is no partial state.

## Configuration
- `MODE_DEBOUNCE_EN` defined: each `MODE_KEY` bit passes through a stable-count filter. The filtered bit changes only after the raw bit has differed for `DEB_CYC` consecutive cycles. This adds `DEB_CYC` cycles to every latency above; `hold_cnt` and `wait_cnt` count the filtered key.
- Not defined: raw keys are used directly and `DEB_CYC` is ignored.

## Test plan
Benches use `NUM_MODES`=4, `BLINK_HALF`=4, `HOLD_CYC`=8, `WAIT_CYC`=6, without the macro unless stated.
- Reset, then idle 20 cycles → `LED`=8'hFF and `MODE_VALID`=0. `BLINK` toggles every 4 cycles.
- `MODE_KEY`=4'b0110 for one cycle → `MODE`=1 next cycle. Then `LED`=8'b11011101 with `Mode_Switch` at 0 or 1.
- Select mode 3, `Mode_Switch`=1 → `LED` alternates 8'b01110111 / 8'hFF every 4 cycles. With `Mode_Switch`=0, `LED` is steady 8'b01110111.
- Select mode 2; hold key 2 for 7 cycles then release → `REC_ARMED` stays 0. Hold for 8 cycles → `REC_ARMED`=1. Release for 6 cycles → `REC_ACTIVE`=1 and `LED` blinks 8'b10111011 / 8'hFF.
- While `REC_ACTIVE`=1, pulse key 0 → `MODE`=0, FSM in IDLE, `LED`=8'b11101110. Assert `RESET` while ARMED → all outputs at reset values next cycle.
- With `MODE_DEBOUNCE_EN`, `DEB_CYC`=5: a 4-cycle key-1 glitch → `MODE` unchanged. A 5-cycle press → `MODE`=1.
